perf_counter_dumper: RTL and testbench
======================================

# perf_counter_dumper

Master-side readout engine for the memory-mapped performance counters at 0xFFF0–0xFFFF. On a start pulse it walks the populated counter addresses, issues one read per address over the data-memory port, and streams each tagged 16-bit value out over a valid/ready port to a debug sink. It can optionally clear the clearable counters (0xFFFC–0xFFFF) after reading them. It sits in the debug path beside the data-memory arbiter.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles to wait for mem_resp on one access before aborting.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request to begin a dump; ignored while busy.
- clear_after  in  1  sampled with start; enables clear-writes to 0xFFFC–0xFFFF.
- mem_address  out  16 (lc3b_word)  counter address being accessed.
- mem_read  out  1  read strobe; held until mem_resp.
- mem_write  out  1  clear-write strobe; held until mem_resp.
- mem_resp  in  1  access complete.
- mem_rdata  in  16 (lc3b_word)  read data, valid with mem_resp.
- out_valid  out  1  tagged sample available.
- out_ready  in  1  sink accepts the sample.
- out_tag  out  4  mem_address[3:0] of the sample.
- out_data  out  16  counter value.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse when a dump finishes or aborts.
- error  out  1  sticky timeout flag; cleared by the next accepted start.

## Operation
- Walk order, indices 0–9: FFF0, FFF1, FFF2, FFF3, FFF4, FFF5, FFFC, FFFD, FFFE, FFFF.
- FSM states:
  - IDLE: start → REQ_READ, with index=0, clear_en=clear_after, error=0.
  - REQ_READ: drive mem_read and the address. On mem_resp, capture mem_rdata → SEND.
  - SEND: drive out_valid, out_tag and out_data. On out_ready: if clear_en and the address is ≥ FFFC → REQ_CLEAR; otherwise → NEXT.
  - REQ_CLEAR: drive mem_write and the same address. On mem_resp → NEXT.
  - NEXT: if index=9 → DONE; otherwise index+1 → REQ_READ.
  - DONE: assert done → IDLE.
- Timeout: an 8-bit wait counter resets on entering REQ_READ or REQ_CLEAR. If it reaches TIMEOUT without mem_resp: set error, drop the strobes, → DONE. Remaining entries are skipped.
- mem_read and mem_write are never asserted together. mem_address is 0 in IDLE, DONE and NEXT.
- Captured data is held stable while out_valid=1 and out_ready=0.
- start is ignored in every state except IDLE.

## Timing
- Reset values: all outputs 0 (including error and mem_address); FSM in IDLE; index 0.
- reset_n low mid-dump: everything returns to reset immediately and asynchronously. There is no done pulse, and no further strobes are issued.
- Start at cycle t → mem_read at t+1.
- With zero-wait memory (mem_resp in the first strobe cycle) and out_ready tied high, each entry takes 3 cycles (REQ_READ, SEND, NEXT), or 4 when clearing.
- Minimum dump length: 30 cycles without clear, 34 with clear; done is high in the following cycle.
- A mem_resp in the same cycle the wait count hits TIMEOUT counts as success.
- out_valid is asserted no earlier than the cycle after the mem_resp that captured the data.

## Structure
- Shared package lc3b_types holds:
  - lc3b_word;
  - the counter address constants (COUNTER_BASE=16'hFFF0, CLEARABLE_BASE=16'hFFFC);
  - the 10-entry walk table, as a constant array of 4-bit offsets;
  - the state enum perf_dump_state_t.
- One sub-module: dump_wait_timer (8-bit counter with restart and expired outputs).
- All other logic (FSM, index register, capture register) lives in the top module.

## Test plan
- Zero-wait memory returning 16'h1000+addr[3:0], out_ready=1, clear_after=0 → 10 samples with tags 0,1,2,3,4,5,C,D,E,F and data 0x1000…0x100F; no mem_write; done at cycle 31.
- Same as above with clear_after=1 → exactly 4 mem_write strobes at FFFC, FFFD, FFFE, FFFF, each directly after its sample is accepted; done at cycle 35.
- out_ready low for 5 cycles on the FFF2 sample → out_data stays 0x1002 and mem_read stays low throughout; the FFF3 read starts 2 cycles after out_ready rises.
- mem_resp withheld at FFF4 with TIMEOUT=8 → error=1, done pulses, busy drops, only 4 samples emitted; a new start clears error.
- reset_n low while in REQ_CLEAR → mem_write, busy and out_valid drop to 0 asynchronously; after release, start begins again at FFF0.
- start pulsed while busy → ignored; the sample count and order are unchanged.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and constants for the performance-counter readout path.
//   lc3b_word          : 16-bit machine word
//   COUNTER_BASE       : first memory-mapped performance counter (0xFFF0)
//   CLEARABLE_BASE     : first counter that may be cleared by a write (0xFFFC)
//   WALK_TABLE         : low-nibble offsets of the populated counters, in dump order
//   perf_dump_state_t  : states of the dump engine
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam lc3b_word COUNTER_BASE   = 16'hFFF0;
  localparam lc3b_word CLEARABLE_BASE = 16'hFFFC;

  localparam int         WALK_LEN  = 10;
  localparam logic [3:0] WALK_LAST = 4'd9;

  // Entry i occupies bits [4*i+3 : 4*i]; 0xFFF6-0xFFFB are not populated.
  localparam logic [WALK_LEN-1:0][3:0] WALK_TABLE = {
    4'hF, 4'hE, 4'hD, 4'hC, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_READ,
    ST_SEND,
    ST_REQ_CLEAR,
    ST_NEXT,
    ST_DONE
  } perf_dump_state_t;

  // Full counter address for a walk index.
  function automatic lc3b_word walk_address(input logic [3:0] index);
    return COUNTER_BASE | lc3b_word'(WALK_TABLE[index]);
  endfunction

endpackage

// File: rtl/dump_wait_timer.sv
// Wait-cycle counter for one memory access of the dump engine.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   restart  : hold the count at zero (asserted whenever no access is pending)
//   expired  : count has reached LIMIT; stays high until restart
// The count is zero in the first strobe cycle, so an access may hold its
// strobe for LIMIT+1 cycles before expired is seen without a response.
module dump_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic expired
);

  localparam logic [7:0] LIMIT_W = 8'(LIMIT);

  logic [7:0] count;

  assign expired = (count == LIMIT_W);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/perf_counter_dumper.sv
// Debug readout engine for the performance counters at 0xFFF0-0xFFFF.
// A start pulse walks the populated counters, reads each over the data-memory
// port, streams the tagged value to a valid/ready sink and, if requested,
// clears the clearable counters (0xFFFC-0xFFFF) right after they are sent.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, clear_after    : begin a dump (ignored unless idle); enable clears
//   mem_address/read/write: memory request, strobes held until mem_resp
//   mem_resp, mem_rdata   : access completion and read data
//   out_valid/ready       : sample handshake; out_tag = address[3:0]
//   out_data              : captured counter value, stable while stalled
//   busy, done, error     : dump in progress, end pulse, sticky timeout flag
module perf_counter_dumper
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       clear_after,
  output lc3b_word   mem_address,
  output logic       mem_read,
  output logic       mem_write,
  input  logic       mem_resp,
  input  lc3b_word   mem_rdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_tag,
  output lc3b_word   out_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  perf_dump_state_t state, state_next;
  logic [3:0]       index;
  logic             clear_en;
  lc3b_word         sample;
  lc3b_word         address;
  logic             waiting;
  logic             wait_expired;

  assign address = walk_address(index);
  assign waiting = (state == ST_REQ_READ) || (state == ST_REQ_CLEAR);

  // The timer runs only while a strobe is outstanding, so it restarts
  // naturally on every entry into REQ_READ or REQ_CLEAR.
  dump_wait_timer #(
    .LIMIT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(!waiting),
    .expired(wait_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      index    <= '0;
      clear_en <= 1'b0;
      error    <= 1'b0;
      sample   <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            index    <= '0;
            clear_en <= clear_after;
            error    <= 1'b0;
          end
        end
        ST_REQ_READ: begin
          // A response in the expiry cycle still counts as success.
          if (mem_resp) begin
            sample <= mem_rdata;
          end else if (wait_expired) begin
            error <= 1'b1;
          end
        end
        ST_REQ_CLEAR: begin
          if (!mem_resp && wait_expired) begin
            error <= 1'b1;
          end
        end
        ST_NEXT: begin
          if (index != WALK_LAST) begin
            index <= index + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    out_valid   = 1'b0;
    out_tag     = '0;
    out_data    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = ST_REQ_READ;
        end
      end
      ST_REQ_READ: begin
        mem_read    = 1'b1;
        mem_address = address;
        if (mem_resp) begin
          state_next = ST_SEND;
        end else if (wait_expired) begin
          state_next = ST_DONE;
        end
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_tag   = address[3:0];
        out_data  = sample;
        if (out_ready) begin
          if (clear_en && (address >= CLEARABLE_BASE)) begin
            state_next = ST_REQ_CLEAR;
          end else begin
            state_next = ST_NEXT;
          end
        end
      end
      ST_REQ_CLEAR: begin
        mem_write   = 1'b1;
        mem_address = address;
        if (mem_resp) begin
          state_next = ST_NEXT;
        end else if (wait_expired) begin
          state_next = ST_DONE;
        end
      end
      ST_NEXT: begin
        state_next = (index == WALK_LAST) ? ST_DONE : ST_REQ_READ;
      end
      ST_DONE: begin
        busy       = 1'b0;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_perf_counter_dumper.sv
// Self-checking bench for perf_counter_dumper: directed scenarios followed by
// randomized dumps, all compared every cycle against a transaction-level model.
module tb_perf_counter_dumper;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_after = 1'b0;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        out_ready = 1'b0;
  logic [15:0] mem_address;
  logic        mem_read, mem_write;
  logic        out_valid;
  logic [3:0]  out_tag;
  logic [15:0] out_data;
  logic        busy, done, error;

  always #5 clk = ~clk;

  perf_counter_dumper #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .clear_after(clear_after),
    .mem_address(mem_address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_tag    (out_tag),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef enum int {EV_READ, EV_SAMPLE, EV_CLEAR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [3:0]  off;
    logic [15:0] data;
  } ev_t;

  int walk[10] = '{0, 1, 2, 3, 4, 5, 12, 13, 14, 15};

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Model: the ordered list of bus/stream events one dump must produce.
  bit  m_active = 0;
  bit  m_error  = 0;
  int  m_done_due = -1;
  int  due = 0;
  int  wait_n = 0;
  ev_t q[$];

  // Environment knobs.
  int          resp_max = 0;
  int          stall_off = -1;
  bit          stall_write = 0;
  int          stall_mode = 0;   // 1: withhold forever, 2: answer on the last legal cycle
  int          ready_pct = 100;
  int          hold_tag = -1;
  int          hold_len = 0;
  bit          noise_start = 0;
  bit          start_req = 0;
  bit          clear_req = 0;
  logic [15:0] mem_val[16];

  // Observations of the DUT used for hand-computed checks.
  int dut_samples, dut_writes, dut_done_cycle, start_cycle;
  int accept_cycle[16], first_read_cycle[16], first_write_cycle[16];
  bit prev_read = 0, prev_write = 0;
  int resp_cnt = 0, strobe_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
    end
  endtask

  task automatic schedule_next();
    wait_n = 0;
    if (q.size() == 0) m_done_due = cycle + 2;
    else if (q[0].kind == EV_READ) due = cycle + 2;
    else due = cycle + 1;
  endtask

  task automatic tick();
    logic        show, exp_rd, exp_wr, exp_val, stalled;
    logic [15:0] exp_addr, exp_data;
    logic [3:0]  exp_tag;
    @(negedge clk);
    cycle++;
    if (!reset_n) begin
      m_active = 0; m_error = 0; m_done_due = -1; q.delete();
      prev_read = 0; prev_write = 0; strobe_n = 0;
      check("reset_ctl", 32'({mem_read, mem_write, out_valid, busy, done, error}), 32'(0));
      check("reset_addr", 32'(mem_address), 32'(0));
      check("reset_tag_data", 32'({out_tag, out_data}), 32'(0));
      start = 0; mem_resp = 0; out_ready = 0;
      return;
    end
    // Compare against the model.
    show     = m_active && (q.size() > 0) && (cycle >= due);
    exp_rd   = show && (q[0].kind == EV_READ);
    exp_wr   = show && (q[0].kind == EV_CLEAR);
    exp_val  = show && (q[0].kind == EV_SAMPLE);
    exp_addr = (exp_rd || exp_wr) ? {12'hFFF, q[0].off} : 16'h0;
    exp_tag  = exp_val ? q[0].off : 4'h0;
    exp_data = exp_val ? q[0].data : 16'h0;
    check("mem_read", 32'(mem_read), 32'(exp_rd));
    check("mem_write", 32'(mem_write), 32'(exp_wr));
    check("mem_address", 32'(mem_address), 32'(exp_addr));
    check("out_valid", 32'(out_valid), 32'(exp_val));
    check("out_tag", 32'(out_tag), 32'(exp_tag));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("done", 32'(done), 32'(cycle == m_done_due));
    check("busy", 32'(busy), 32'(m_active && (cycle != m_done_due)));
    check("error", 32'(error), 32'(m_error));
    if (done) dut_done_cycle = cycle;
    if (mem_read && !prev_read) first_read_cycle[mem_address[3:0]] = cycle;
    if (mem_write && !prev_write) first_write_cycle[mem_address[3:0]] = cycle;
    prev_read  = mem_read;
    prev_write = mem_write;
    // Memory responder.
    if (mem_read || mem_write) begin
      if (strobe_n == 0) resp_cnt = int'($urandom_range(resp_max, 0));
      stalled = (int'(mem_address[3:0]) == stall_off) && (mem_write == stall_write);
      if (stalled) mem_resp = (stall_mode == 2) && (strobe_n == TMO);
      else mem_resp = (strobe_n >= resp_cnt);
      strobe_n++;
    end else begin
      mem_resp = 0;
      strobe_n = 0;
    end
    mem_rdata = mem_resp ? mem_val[mem_address[3:0]] : 16'($urandom);
    if (mem_write && mem_resp) dut_writes++;
    // Sink.
    if (out_valid && (int'(out_tag) == hold_tag) && (hold_len > 0)) begin
      out_ready = 0;
      hold_len--;
    end else begin
      out_ready = (int'($urandom_range(99, 0)) < ready_pct);
    end
    if (out_valid && out_ready) begin
      dut_samples++;
      accept_cycle[out_tag] = cycle;
    end
    // Start requests.
    if (start_req) begin
      start = 1; clear_after = clear_req; start_req = 0; start_cycle = cycle;
    end else if (noise_start && m_active) begin
      start = 1'($urandom_range(1, 0)); clear_after = 1'($urandom_range(1, 0));
    end else begin
      start = 0; clear_after = 1'($urandom_range(1, 0));
    end
    // Advance the model across the coming rising edge.
    if (m_active) begin
      if (cycle == m_done_due) begin
        m_active = 0;
      end else if (show) begin
        if (q[0].kind == EV_SAMPLE) begin
          if (out_ready) begin void'(q.pop_front()); schedule_next(); end
        end else if (mem_resp) begin
          void'(q.pop_front()); schedule_next();
        end else if (wait_n == TMO) begin
          m_error = 1; q.delete(); m_done_due = cycle + 1;
        end else begin
          wait_n++;
        end
      end
    end else if (start) begin
      m_active = 1; m_error = 0; m_done_due = -1; wait_n = 0; due = cycle + 1;
      q.delete();
      foreach (walk[i]) begin
        q.push_back('{EV_READ, 4'(walk[i]), mem_val[walk[i]]});
        q.push_back('{EV_SAMPLE, 4'(walk[i]), mem_val[walk[i]]});
        if (clear_after && walk[i] >= 12) q.push_back('{EV_CLEAR, 4'(walk[i]), 16'h0});
      end
    end
  endtask

  task automatic run_dump(input bit clr, input int max_cycles);
    int n;
    dut_samples = 0; dut_writes = 0; dut_done_cycle = -1;
    for (int i = 0; i < 16; i++) begin
      accept_cycle[i] = -1; first_read_cycle[i] = -1; first_write_cycle[i] = -1;
    end
    start_req = 1; clear_req = clr;
    tick();
    n = 1;
    while (m_active && n < max_cycles) begin
      tick();
      n++;
    end
    check("dump_completes", 32'(m_active), 32'(0));
  endtask

  task automatic fixed_memory();
    for (int i = 0; i < 16; i++) mem_val[i] = 16'h1000 + 16'(i);
  endtask

  initial begin
    int n;
    fixed_memory();
    repeat (3) tick();
    #2 reset_n = 1;
    repeat (2) tick();

    // Zero-wait dump, no clears.
    run_dump(0, 200);
    check("t1_done_cycle", 32'(dut_done_cycle - start_cycle), 32'(31));
    check("t1_samples", 32'(dut_samples), 32'(10));
    check("t1_writes", 32'(dut_writes), 32'(0));
    check("t1_first_read", 32'(first_read_cycle[0] - start_cycle), 32'(1));

    // Zero-wait dump with clears.
    run_dump(1, 200);
    check("t2_done_cycle", 32'(dut_done_cycle - start_cycle), 32'(35));
    check("t2_samples", 32'(dut_samples), 32'(10));
    check("t2_writes", 32'(dut_writes), 32'(4));
    for (int i = 12; i < 16; i++)
      check("t2_write_after_accept", 32'(first_write_cycle[i] - accept_cycle[i]), 32'(1));
    check("t2_no_write_fff5", 32'(first_write_cycle[5]), 32'(-1));

    // Sink stalls 5 cycles on the FFF2 sample.
    hold_tag = 2; hold_len = 5;
    run_dump(0, 200);
    hold_tag = -1;
    check("t3_done_cycle", 32'(dut_done_cycle - start_cycle), 32'(36));
    check("t3_read3_gap", 32'(first_read_cycle[3] - accept_cycle[2]), 32'(2));

    // Response withheld at FFF4: timeout.
    stall_off = 4; stall_write = 0; stall_mode = 1;
    run_dump(0, 200);
    check("t4_samples", 32'(dut_samples), 32'(4));
    check("t4_error", 32'(error), 32'(1));
    check("t4_busy", 32'(busy), 32'(0));
    check("t4_done_gap", 32'(dut_done_cycle - first_read_cycle[4]), 32'(TMO + 1));
    // Answer arriving on the last legal cycle is a success.
    stall_mode = 2;
    run_dump(0, 200);
    check("t4b_error_cleared", 32'(error), 32'(0));
    check("t4b_samples", 32'(dut_samples), 32'(10));
    check("t4b_done_cycle", 32'(dut_done_cycle - start_cycle), 32'(31 + TMO));
    stall_off = -1; stall_mode = 0;

    // Asynchronous reset while a clear write is pending.
    stall_off = 12; stall_write = 1; stall_mode = 1;
    start_req = 1; clear_req = 1;
    n = 0;
    do begin tick(); n++; end while (!mem_write && n < 100);
    check("t5_reached_clear", 32'(mem_write), 32'(1));
    #2 reset_n = 0;
    #1;
    check("t5_async_write", 32'(mem_write), 32'(0));
    check("t5_async_busy", 32'(busy), 32'(0));
    check("t5_async_valid", 32'(out_valid), 32'(0));
    repeat (2) tick();
    #2 reset_n = 1;
    stall_off = -1; stall_write = 0; stall_mode = 0;
    repeat (3) tick();
    run_dump(0, 200);
    check("t5_restart_fff0", 32'(first_read_cycle[0] - start_cycle), 32'(1));
    check("t5_samples", 32'(dut_samples), 32'(10));

    // Start pulses while busy are ignored.
    noise_start = 1;
    run_dump(1, 200);
    noise_start = 0;
    check("t6_done_cycle", 32'(dut_done_cycle - start_cycle), 32'(35));
    check("t6_samples", 32'(dut_samples), 32'(10));
    check("t6_writes", 32'(dut_writes), 32'(4));

    // Randomized dumps.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 16; i++) mem_val[i] = 16'($urandom);
      resp_max    = int'($urandom_range(3, 0));
      ready_pct   = int'($urandom_range(100, 40));
      noise_start = 1'($urandom_range(1, 0));
      stall_off   = -1;
      if ($urandom_range(3, 0) == 0) begin
        stall_off   = walk[$urandom_range(9, 0)];
        stall_write = (stall_off >= 12) ? 1'($urandom_range(1, 0)) : 1'b0;
        stall_mode  = int'($urandom_range(2, 1));
      end
      run_dump(1'($urandom_range(1, 0)), 3000);
      repeat (int'($urandom_range(3, 0))) tick();
    end
    noise_start = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
